// File: rtl/l1_bus_unit.sv
// Cache-side bus interface unit: runs L1-D single and line requests as 64-bit beats on a
// req/ack memory bus and returns refill beats, completion and error pulses to the L1.
module l1_bus_unit #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned LINE_BEATS = 2048,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_through_req,
  input  logic                  read_req,
  input  logic                  read_line_req,
  input  logic                  write_line_req,
  input  logic [3:0]            L1_size,
  input  logic [63:0]           pa,
  input  logic [63:0]           wt_data,
  output logic [63:0]           line_data,
  output logic [10:0]           addr_count,
  output logic                  line_write,
  output logic                  cache_entry_refill,
  output logic                  trans_rdy,
  output logic                  bus_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_bsel,
  output logic [63:0]           mem_wdata,
  input  logic [63:0]           mem_rdata,
  input  logic                  mem_ack,
  input  logic                  mem_err
);

  localparam int unsigned OFF_BITS = $clog2(LINE_BEATS) + 3;
  localparam int unsigned BW       = $clog2(LINE_BEATS) + 1;
  localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_BITS;

  typedef enum logic [2:0] {
    StIdle, StSrd, StSwr, StLrd, StLwrFetch, StLwrBeat, StErr
  } state_e;

  state_e                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [63:0]           line_data_d, mem_wdata_d;
  logic [10:0]           addr_count_d;
  logic                  line_write_d, refill_d, trans_rdy_d, bus_error_d;
  logic                  mem_req_d, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [7:0]            mem_bsel_d;

  logic [7:0]            size_mask;
  logic [3:0]            size_bytes;
  logic                  size_ok;
  logic [7:0]            single_bsel;
  logic                  timed_out, resp_ok, resp_fail;
  logic                  unused_pa;

  assign unused_pa = ^pa[63:ADDR_WIDTH];

  always_comb begin
    size_mask  = 8'h00;
    size_bytes = 4'd0;
    case (L1_size)
      4'b0001: begin size_mask = 8'h01; size_bytes = 4'd1; end
      4'b0010: begin size_mask = 8'h03; size_bytes = 4'd2; end
      4'b0100: begin size_mask = 8'h0F; size_bytes = 4'd4; end
      4'b1000: begin size_mask = 8'hFF; size_bytes = 4'd8; end
      default: ;
    endcase
    // The access must fit inside the addressed 8-byte word.
    size_ok     = (size_bytes != 4'd0) && (({1'b0, pa[2:0]} + size_bytes) <= 4'd8);
    single_bsel = size_mask << pa[2:0];
  end

  assign timed_out = (TIMEOUT != 0) && (tmo_q == TW'(TMO_LAST)) && !mem_ack;
  assign resp_ok   = mem_req && mem_ack && !mem_err;
  assign resp_fail = mem_req && (mem_err || timed_out);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    base_d       = base_q;
    tmo_d        = mem_req ? tmo_q + TW'(1) : '0;
    line_data_d  = line_data;
    addr_count_d = addr_count;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_bsel_d   = mem_bsel;
    mem_wdata_d  = mem_wdata;
    line_write_d = 1'b0;
    refill_d     = 1'b0;
    trans_rdy_d  = 1'b0;
    bus_error_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (write_line_req || read_line_req || read_req || write_through_req) begin
          addr_count_d = '0;
          beat_d       = '0;
          base_d       = pa[ADDR_WIDTH-1:0] & LINE_MASK;
          if (write_line_req) begin
            state_d    = StLwrFetch;
            mem_we_d   = 1'b1;
            mem_bsel_d = 8'hFF;
          end else if (read_line_req) begin
            state_d    = StLrd;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pa[ADDR_WIDTH-1:0] & LINE_MASK;
            mem_bsel_d = 8'hFF;
          end else if (!size_ok) begin
            state_d     = StErr;
            bus_error_d = 1'b1;
          end else begin
            state_d    = read_req ? StSrd : StSwr;
            mem_req_d  = 1'b1;
            mem_we_d   = !read_req;
            mem_addr_d = {pa[ADDR_WIDTH-1:3], 3'b000};
            mem_bsel_d = single_bsel;
            if (!read_req) mem_wdata_d = wt_data;
          end
        end
      end
      StSrd: begin
        if (resp_ok) begin
          line_data_d = mem_rdata;
          trans_rdy_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = StIdle;
        end
      end
      StSwr: begin
        if (resp_ok) begin
          trans_rdy_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = StIdle;
        end
      end
      StLrd: begin
        if (mem_req) begin
          if (resp_ok) begin
            line_data_d  = mem_rdata;
            line_write_d = 1'b1;
            addr_count_d = 11'(beat_q);
            beat_d       = beat_q + BW'(1);
            mem_req_d    = 1'b0;
          end
        end else if (beat_q == BW'(LINE_BEATS)) begin
          refill_d    = 1'b1;
          trans_rdy_d = 1'b1;
          state_d     = StIdle;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = base_q + ADDR_WIDTH'({beat_q, 3'b000});
        end
      end
      // One cycle of addr_count before the beat covers the L1 SRAM read latency.
      StLwrFetch: state_d = StLwrBeat;
      StLwrBeat: begin
        if (!mem_req) begin
          mem_req_d   = 1'b1;
          mem_wdata_d = wt_data;
          mem_addr_d  = base_q + ADDR_WIDTH'({beat_q, 3'b000});
        end else if (resp_ok) begin
          mem_req_d = 1'b0;
          if (beat_q == BW'(LINE_BEATS - 1)) begin
            trans_rdy_d = 1'b1;
            state_d     = StIdle;
          end else begin
            beat_d       = beat_q + BW'(1);
            addr_count_d = addr_count + 11'd1;
            state_d      = StLwrFetch;
          end
        end
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && resp_fail) begin
      state_d      = StErr;
      mem_req_d    = 1'b0;
      bus_error_d  = 1'b1;
      line_write_d = 1'b0;
      trans_rdy_d  = 1'b0;
      refill_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= StIdle;
      beat_q             <= '0;
      tmo_q              <= '0;
      base_q             <= '0;
      line_data          <= '0;
      addr_count         <= '0;
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= '0;
      mem_bsel           <= '0;
      mem_wdata          <= '0;
    end else begin
      state_q            <= state_d;
      beat_q             <= beat_d;
      tmo_q              <= tmo_d;
      base_q             <= base_d;
      line_data          <= line_data_d;
      addr_count         <= addr_count_d;
      line_write         <= line_write_d;
      cache_entry_refill <= refill_d;
      trans_rdy          <= trans_rdy_d;
      bus_error          <= bus_error_d;
      mem_req            <= mem_req_d;
      mem_we             <= mem_we_d;
      mem_addr           <= mem_addr_d;
      mem_bsel           <= mem_bsel_d;
      mem_wdata          <= mem_wdata_d;
    end
  end

endmodule
